data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder on the far side of the memory-stage interface. Accepts the load/store request driven combinationally from the memory-stage pipe buffer (read/write strobes, address, store data), performs the access against an internal word array with a fixed multi-cycle latency, holds the pipeline with a stall request while the access is in flight, and returns load data on `readData_M` in the cycle the stall drops.

## Interface
- `width`, 32: data and address width.
- `depthLog2`, 10: log2 of array depth in words (1024 words).
- `latency`, 2: access latency in cycles; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `memRead_M`  in  1  load request.
- `memWrite_M`  in  1  store request.
- `addr_M`  in  width  byte address (the memory stage's ALU result).
- `writeData_M`  in  width  store data.
- `readData_M`  out  width  load data; valid in DONE.
- `memStall`  out  1  stall request to the hazard unit (drives `stall_M` and upstream stalls).
- `misaligned`  out  1  `addr_M[1:0] != 0` while a request is present; informational only.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request (`memRead_M | memWrite_M` = 0): stay in IDLE, `memStall` = 0.
  - Request present: load the counter with `latency`-1, assert `memStall` combinationally the same cycle, and go to BUSY. If `latency` = 1, go directly to DONE.
- BUSY:
  - `memStall` = 1.
  - Counter decrements each cycle.
  - When the counter = 0, perform the access on the clock edge and go to DONE.
- DONE:
  - `memStall` = 0, so the pipeline advances this cycle.
  - `readData_M` holds the captured word.
  - Next state is unconditionally IDLE. The request visible in DONE is the one just completed and is not re-accepted.
- Request stability: inputs are held stable by the stalled pipe buffer throughout BUSY. The block samples the address and data at the commit edge, not at acceptance.
- Addressing: word index = `addr_M[depthLog2+1:2]`. Upper bits are ignored, so addresses wrap modulo the array size. Low two bits are ignored for the access.
- Store: writes the full word at the commit edge. `readData_M` in DONE returns the pre-write contents of that word.
- Both strobes asserted: treated as a store. `readData_M` returns the old contents.
- Load: captures the array word into the `readData_M` register at the commit edge.
- Array contents are not reset.

## Timing
- Reset values: state IDLE, counter 0, `readData_M` 0, `memStall` 0, `misaligned` 0.
- Request first visible in cycle t:
  - `memStall` is high in cycles t .. t+`latency`-1.
  - DONE occurs in cycle t+`latency`; the pipe buffer advances at the end of that cycle.
  - Memory-stage occupancy is `latency`+1 cycles.
- Back-to-back memory ops: the second request appears at t+`latency`+1 in IDLE and is accepted immediately, with no bubble beyond DONE.
- `readData_M` changes only at a commit edge or on reset. It holds its value through IDLE for non-load instructions.
- Reset mid-BUSY: next cycle the state is IDLE and `memStall` = 0. The pending store is not committed and no array write occurs.
- `misaligned` is combinational from the inputs and is 0 when no request is present.

## Structure
- Shared package `mem_pkg`:
  - state enum `memState_t` {IDLE, BUSY, DONE};
  - `WORD_OFFSET` = 2.
- Sub-module `data_ram_array`:
  - parameters `width`, `depthLog2`;
  - single port, synchronous write, synchronous read registered on the same edge;
  - read returns old data on a same-address write (read-first).
- The top level holds the FSM, the 4-bit down-counter, stall generation and decode.

## Test plan
- Reset, then store 0xDEADBEEF to addr 0x40 with `latency`=2 -> `memStall` high exactly 2 cycles, DONE on cycle 3; a subsequent load from 0x40 returns 0xDEADBEEF in its DONE cycle.
- Load from 0x40 immediately followed by load from 0x44 (holding 0x12345678) -> stall pattern 1,1,0,1,1,0; `readData_M` = 0xDEADBEEF, then 0x12345678.
- Both strobes set, addr 0x80 (old 0x11), data 0x22 -> DONE `readData_M` = 0x11; a later load returns 0x22.
- Address wrap with `depthLog2`=10: store 0xA5 to 0x1000, load from 0x0000 -> 0xA5. Load from 0x42 -> `misaligned`=1, returns the word at 0x40.
- Assert `reset` in the second BUSY cycle of a store of 0x55 to 0x20 (old 0x0) -> `memStall` 0 the next cycle; a later load from 0x20 returns 0x0.
- Sweep `latency` over 1 and 15 -> `memStall` width equals `latency`; with `latency`=1, IDLE goes directly to DONE.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory responder
// Exports: memState_t (IDLE/BUSY/DONE), WORD_OFFSET (byte-to-word shift)
package mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} memState_t;
    localparam int WORD_OFFSET = 2;
endpackage

// File: rtl/data_ram_array.sv
// data_ram_array: single-port word array, sync write, read-first registered read
// Ports: clk, reset (clears read register only), en (access strobe), we (write),
//        addr (word index), wdata, rdata (registered, updated only when en)
module data_ram_array #(
    parameter int width = 32,
    parameter int depthLog2 = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 we,
    input  logic [depthLog2-1:0] addr,
    input  logic [width-1:0]     wdata,
    output logic [width-1:0]     rdata
);
    logic [width-1:0] mem [2**depthLog2];

    always_ff @(posedge clk)
        if (en && we) mem[addr] <= wdata;

    // Read register sees the pre-write word because both use the same edge
    always_ff @(posedge clk)
        if (reset) rdata <= '0;
        else if (en) rdata <= mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory with pipeline stall request
// Ports: clk, reset (sync, active-high), memRead_M, memWrite_M, addr_M,
//        writeData_M in; readData_M (valid in DONE), memStall, misaligned out
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int width = 32,
    parameter int depthLog2 = 10,
    parameter int latency = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memRead_M,
    input  logic             memWrite_M,
    input  logic [width-1:0] addr_M,
    input  logic [width-1:0] writeData_M,
    output logic [width-1:0] readData_M,
    output logic             memStall,
    output logic             misaligned
);
    memState_t state, next_state;
    logic [3:0] cnt;
    logic req, commit, unused_addr;

    assign req = memRead_M | memWrite_M;
    assign unused_addr = ^addr_M[width-1:depthLog2+WORD_OFFSET];

    // Commit on the last stalled cycle: either the accept cycle itself when
    // latency is 1, or the BUSY cycle whose counter is about to reach zero.
    // Reset suppresses the commit so an interrupted store never lands.
    assign commit = !reset && ((state == IDLE && req && latency == 1) ||
                               (state == BUSY && cnt == 4'd1));

    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (state == IDLE && req) ? 4'(latency - 1) :
                     (state == BUSY) ? cnt - 4'd1 : cnt;
        end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: next_state = req ? (latency == 1 ? DONE : BUSY) : IDLE;
            BUSY: next_state = (cnt == 4'd1) ? DONE : BUSY;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        memStall   = (state == BUSY) || (state == IDLE && req);
        misaligned = req && (addr_M[WORD_OFFSET-1:0] != '0);
    end

    data_ram_array #(.width(width), .depthLog2(depthLog2)) u_ram (
        .clk(clk),
        .reset(reset),
        .en(commit),
        .we(memWrite_M),
        .addr(addr_M[depthLog2+WORD_OFFSET-1:WORD_OFFSET]),
        .wdata(writeData_M),
        .rdata(readData_M)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized self-checking bench with a word-array reference model
module tb_data_mem_responder;
    logic clk = 0, reset = 1, mr = 0, mw = 0;
    logic [31:0] addr = 0, wd = 0;
    logic [31:0] rd2, rd1, rd15;
    logic st2, st1, st15, mis2, mis1, mis15;
    int vectors = 0, miscompares = 0;
    logic [31:0] mem [1024];
    bit valid [1024];
    logic [31:0] rd_model = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.width(32), .depthLog2(10), .latency(2)) dut2 (
        .clk(clk), .reset(reset), .memRead_M(mr), .memWrite_M(mw), .addr_M(addr),
        .writeData_M(wd), .readData_M(rd2), .memStall(st2), .misaligned(mis2));
    data_mem_responder #(.width(32), .depthLog2(10), .latency(1)) dut1 (
        .clk(clk), .reset(reset), .memRead_M(mr), .memWrite_M(mw), .addr_M(addr),
        .writeData_M(wd), .readData_M(rd1), .memStall(st1), .misaligned(mis1));
    data_mem_responder #(.width(32), .depthLog2(10), .latency(15)) dut15 (
        .clk(clk), .reset(reset), .memRead_M(mr), .memWrite_M(mw), .addr_M(addr),
        .writeData_M(wd), .readData_M(rd15), .memStall(st15), .misaligned(mis15));

    task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int idx;
        logic [31:0] exp;
        logic m;
        idx = int'(a[11:2]);
        exp = mem[idx];
        m = (a[1:0] != 2'b00);
        @(negedge clk);
        mr = r; mw = w; addr = a; wd = d;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (st2 !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_busy addr=%h cyc=%0d got %b want 1", a, i, st2);
            end
            if (i == 0) begin
                vectors++;
                if (mis2 !== m) begin
                    miscompares++;
                    $display("FAIL misaligned addr=%h got %b want %b", a, mis2, m);
                end
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (st2 !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done addr=%h got %b want 0", a, st2);
        end
        vectors++;
        if (rd2 !== exp) begin
            miscompares++;
            $display("FAIL read_data addr=%h r=%b w=%b got %h want %h", a, r, w, rd2, exp);
        end
        rd_model = exp;
        if (w) begin
            mem[idx] = d;
            valid[idx] = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mr = 0; mw = 0; addr = $urandom; wd = $urandom;
            #1;
            vectors++;
            if (st2 !== 1'b0 || mis2 !== 1'b0 || rd2 !== rd_model) begin
                miscompares++;
                $display("FAIL idle_hold got stall=%b mis=%b rd=%h want 0 0 %h", st2, mis2, rd2, rd_model);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1; mr = 0; mw = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        vectors++;
        if (st2 !== 1'b0 || mis2 !== 1'b0 || rd2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state got stall=%b mis=%b rd=%h want 0 0 0", st2, mis2, rd2);
        end
        rd_model = 0;
    endtask

    task automatic test_store_load;
        op(0, 1, 32'h40, 32'hDEADBEEF);
        idle(1);
        op(1, 0, 32'h40, 0);
        op(0, 1, 32'h44, 32'h12345678);
        idle(2);
    endtask

    task automatic test_back_to_back;
        op(1, 0, 32'h40, 0);
        op(1, 0, 32'h44, 0);
        idle(1);
    endtask

    task automatic test_both_strobes;
        op(0, 1, 32'h80, 32'h11);
        op(1, 1, 32'h80, 32'h22);
        idle(1);
        op(1, 0, 32'h80, 0);
    endtask

    task automatic test_wrap_misaligned;
        op(0, 1, 32'h1000, 32'hA5);
        op(1, 0, 32'h0000, 0);
        op(1, 0, 32'h42, 0);
        idle(1);
    endtask

    task automatic test_reset_mid_busy;
        op(0, 1, 32'h20, 32'h0);
        idle(1);
        @(negedge clk);
        mr = 0; mw = 1; addr = 32'h20; wd = 32'h55;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0; mw = 0;
        #1;
        vectors++;
        if (st2 !== 1'b0 || rd2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_busy got stall=%b rd=%h want 0 0", st2, rd2);
        end
        rd_model = 0;
        op(1, 0, 32'h20, 0);
        idle(1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 80; n++) begin
            int idx, k;
            logic [31:0] a;
            idx = $urandom_range(0, 1023);
            k = $urandom_range(0, 2);
            if (!valid[idx] && k == 0) k = 1;
            a = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            op(k != 1, k != 0, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
    endtask

    task automatic test_latency_sweep;
        int run1, run15;
        bit on1, on15;
        reset = 1;
        @(negedge clk);
        reset = 0; mr = 0; mw = 0;
        @(negedge clk);
        mw = 1; addr = 32'h100; wd = $urandom;
        run1 = 0; run15 = 0; on1 = 1; on15 = 1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (on1 && st1) run1++; else on1 = 0;
            if (on15 && st15) run15++; else on15 = 0;
            @(negedge clk);
        end
        mw = 0;
        vectors++;
        if (run1 != 1) begin
            miscompares++;
            $display("FAIL stall_width_lat1 got %0d want 1", run1);
        end
        vectors++;
        if (run15 != 15) begin
            miscompares++;
            $display("FAIL stall_width_lat15 got %0d want 15", run15);
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_back_to_back;
        test_both_strobes;
        test_wrap_misaligned;
        test_reset_mid_busy;
        test_random;
        test_latency_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
